// File: rtl/mc_control_if.sv
// Control bundle between the multi-cycle MIPS control FSM and its datapath:
// opcode from the IR toward the FSM, write enables and mux selects back out.
interface mc_control_if;
  logic [5:0] opcode;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic       instr_done;

  modport master (
    input  opcode,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, instr_done
  );

  modport slave (
    output opcode,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, instr_done
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Moore control FSM for a multi-cycle MIPS datapath with a retired-instruction
// counter. Define MC_CTRL_ADDI_EN to add the addi path (states ADDIEX/ADDIWB).
module mc_control_fsm #(
  parameter int STATE_W = 4,
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  mc_control_if.master       ctrl,
  output logic [COUNT_W-1:0] instr_count,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RTWB, BRANCH, JUMP
`ifdef MC_CTRL_ADDI_EN
    , ADDIEX, ADDIWB
`endif
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  state_t             state_q;
  state_t             state_d;
  state_t             dec_st;
  logic               done;
  logic [COUNT_W-1:0] count_q;

  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    ok = (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
         (op == OP_BEQ) || (op == OP_J);
`ifdef MC_CTRL_ADDI_EN
    ok = ok || (op == OP_ADDI);
`endif
    return ok;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (done) count_q <= count_q + COUNT_W'(1);
    end
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (ctrl.opcode)
          OP_R:          state_d = EXEC;
          OP_LW, OP_SW:  state_d = MEMADR;
          OP_BEQ:        state_d = BRANCH;
          OP_J:          state_d = JUMP;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:       state_d = ADDIEX;
`endif
          default:       state_d = FETCH;
        endcase
      end
      MEMADR: begin
        if (ctrl.opcode == OP_LW)      state_d = MEMRD;
        else if (ctrl.opcode == OP_SW) state_d = MEMWR;
        else                           state_d = FETCH;
      end
      MEMRD:  state_d = MEMWB;
      EXEC:   state_d = RTWB;
`ifdef MC_CTRL_ADDI_EN
      ADDIEX: state_d = ADDIWB;
`endif
      default: state_d = FETCH;
    endcase
  end

  // While reset is high the selects present FETCH values and every strobe is held low.
  always_comb begin
    dec_st             = reset ? FETCH : state_q;
    ctrl.pc_write      = 1'b0;
    ctrl.pc_write_cond = 1'b0;
    ctrl.i_or_d        = 1'b0;
    ctrl.mem_read      = 1'b0;
    ctrl.mem_write     = 1'b0;
    ctrl.ir_write      = 1'b0;
    ctrl.mem_to_reg    = 1'b0;
    ctrl.reg_dst       = 1'b0;
    ctrl.reg_write     = 1'b0;
    ctrl.alu_src_a     = 1'b0;
    ctrl.alu_src_b     = 2'b00;
    ctrl.alu_op        = 2'b00;
    ctrl.pc_source     = 2'b00;
    done               = 1'b0;
    case (dec_st)
      FETCH:  begin ctrl.mem_read = 1'b1; ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1; ctrl.alu_src_b = 2'b01; end
      DECODE: ctrl.alu_src_b = 2'b11;
      MEMADR: begin ctrl.alu_src_a = 1'b1; ctrl.alu_src_b = 2'b10; end
      MEMRD:  begin ctrl.mem_read = 1'b1; ctrl.i_or_d = 1'b1; end
      MEMWB:  begin ctrl.reg_write = 1'b1; ctrl.mem_to_reg = 1'b1; done = 1'b1; end
      MEMWR:  begin ctrl.mem_write = 1'b1; ctrl.i_or_d = 1'b1; done = 1'b1; end
      EXEC:   begin ctrl.alu_src_a = 1'b1; ctrl.alu_op = 2'b10; end
      RTWB:   begin ctrl.reg_write = 1'b1; ctrl.reg_dst = 1'b1; done = 1'b1; end
      BRANCH: begin ctrl.alu_src_a = 1'b1; ctrl.alu_op = 2'b01;
                    ctrl.pc_write_cond = 1'b1; ctrl.pc_source = 2'b01; done = 1'b1; end
      JUMP:   begin ctrl.pc_write = 1'b1; ctrl.pc_source = 2'b10; done = 1'b1; end
`ifdef MC_CTRL_ADDI_EN
      ADDIEX: begin ctrl.alu_src_a = 1'b1; ctrl.alu_src_b = 2'b10; end
      ADDIWB: begin ctrl.reg_write = 1'b1; done = 1'b1; end
`endif
      default: ;
    endcase
    if (reset) begin
      ctrl.pc_write = 1'b0;
      ctrl.mem_read = 1'b0;
      ctrl.ir_write = 1'b0;
    end
    ctrl.instr_done = done;
    ctrl.illegal_op = !reset && (state_q == DECODE) && !op_legal(ctrl.opcode);
  end

  assign instr_count = count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm (counter narrowed to 4 bits to reach wrap).
module tb_mc_control_fsm;
  logic       clk;
  logic       reset;
  logic [3:0] instr_count;
  logic [3:0] state;
  int         checks;
  int         failures;
  int         exp_cnt;

  mc_control_if ifc ();

  mc_control_fsm #(.STATE_W(4), .COUNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .ctrl        (ifc.master),
    .instr_count (instr_count),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] exp_state);
    @(posedge clk);
    #1;
    chk("state", 32'(state), 32'(exp_state));
  endtask

  initial begin
    checks = 0; failures = 0; exp_cnt = 0;
    reset = 1'b1;
    ifc.opcode = 6'h00;
    #1;
    chk("rst_mem_read", 32'(ifc.mem_read), 0);
    chk("rst_pc_write", 32'(ifc.pc_write), 0);
    chk("rst_ir_write", 32'(ifc.ir_write), 0);
    chk("rst_alu_src_b", 32'(ifc.alu_src_b), 1);
    for (int i = 0; i < 3; i++) begin
      step(4'd0);
      chk("rst_reg_write", 32'(ifc.reg_write), 0);
      chk("rst_instr_done", 32'(ifc.instr_done), 0);
      chk("rst_count", 32'(instr_count), 0);
    end
    reset = 1'b0;
    #1;
    chk("fetch_mem_read", 32'(ifc.mem_read), 1);
    chk("fetch_ir_write", 32'(ifc.ir_write), 1);
    chk("fetch_pc_write", 32'(ifc.pc_write), 1);

    // lw
    ifc.opcode = 6'h23;
    step(4'd1);
    chk("dec_alu_src_b", 32'(ifc.alu_src_b), 3);
    chk("dec_illegal", 32'(ifc.illegal_op), 0);
    step(4'd2);
    chk("memadr_src_b", 32'(ifc.alu_src_b), 2);
    step(4'd3);
    chk("memrd_mem_read", 32'(ifc.mem_read), 1);
    chk("memrd_i_or_d", 32'(ifc.i_or_d), 1);
    step(4'd4);
    chk("memwb_reg_write", 32'(ifc.reg_write), 1);
    chk("memwb_mem_to_reg", 32'(ifc.mem_to_reg), 1);
    chk("memwb_done", 32'(ifc.instr_done), 1);
    chk("memwb_count", 32'(instr_count), 0);
    step(4'd0);
    exp_cnt = 1;
    chk("lw_count", 32'(instr_count), 32'(exp_cnt));

    // sw
    ifc.opcode = 6'h2B;
    chk("sw_fetch_mem_write", 32'(ifc.mem_write), 0);
    step(4'd1);
    step(4'd2);
    chk("sw_memadr_mem_write", 32'(ifc.mem_write), 0);
    step(4'd5);
    chk("memwr_mem_write", 32'(ifc.mem_write), 1);
    chk("memwr_reg_write", 32'(ifc.reg_write), 0);
    chk("memwr_i_or_d", 32'(ifc.i_or_d), 1);
    step(4'd0);
    exp_cnt = 2;
    chk("sw_count", 32'(instr_count), 32'(exp_cnt));

    // R-type
    ifc.opcode = 6'h00;
    step(4'd1);
    step(4'd6);
    chk("exec_alu_op", 32'(ifc.alu_op), 2);
    chk("exec_src_a", 32'(ifc.alu_src_a), 1);
    step(4'd7);
    chk("rtwb_reg_dst", 32'(ifc.reg_dst), 1);
    chk("rtwb_reg_write", 32'(ifc.reg_write), 1);
    step(4'd0);

    // beq
    ifc.opcode = 6'h04;
    step(4'd1);
    step(4'd8);
    chk("br_alu_op", 32'(ifc.alu_op), 1);
    chk("br_pc_write_cond", 32'(ifc.pc_write_cond), 1);
    chk("br_pc_source", 32'(ifc.pc_source), 1);
    chk("br_pc_write", 32'(ifc.pc_write), 0);
    step(4'd0);

    // j
    ifc.opcode = 6'h02;
    step(4'd1);
    step(4'd9);
    chk("j_pc_source", 32'(ifc.pc_source), 2);
    chk("j_pc_write", 32'(ifc.pc_write), 1);
    step(4'd0);
    exp_cnt = 5;
    chk("rbj_count", 32'(instr_count), 32'(exp_cnt));

    // illegal opcode
    ifc.opcode = 6'h3F;
    step(4'd1);
    chk("ill_illegal_op", 32'(ifc.illegal_op), 1);
    chk("ill_done", 32'(ifc.instr_done), 0);
    step(4'd0);
    chk("ill_illegal_clear", 32'(ifc.illegal_op), 0);
    chk("ill_count", 32'(instr_count), 32'(exp_cnt));

    // addi
    ifc.opcode = 6'h08;
    step(4'd1);
`ifdef MC_CTRL_ADDI_EN
    chk("addi_illegal_op", 32'(ifc.illegal_op), 0);
    step(4'd10);
    chk("addiex_src_b", 32'(ifc.alu_src_b), 2);
    chk("addiex_src_a", 32'(ifc.alu_src_a), 1);
    step(4'd11);
    chk("addiwb_reg_write", 32'(ifc.reg_write), 1);
    chk("addiwb_reg_dst", 32'(ifc.reg_dst), 0);
    step(4'd0);
    exp_cnt = 6;
`else
    chk("addi_illegal_op", 32'(ifc.illegal_op), 1);
    step(4'd0);
`endif
    chk("addi_count", 32'(instr_count), 32'(exp_cnt));

    // reset in the middle of lw
    ifc.opcode = 6'h23;
    step(4'd1);
    step(4'd2);
    step(4'd3);
    reset = 1'b1;
    #1;
    chk("abort_mem_read", 32'(ifc.mem_read), 0);
    chk("abort_reg_write", 32'(ifc.reg_write), 0);
    chk("abort_i_or_d", 32'(ifc.i_or_d), 0);
    chk("abort_src_b", 32'(ifc.alu_src_b), 1);
    step(4'd0);
    chk("abort_count", 32'(instr_count), 0);
    reset = 1'b0;
    #1;
    chk("abort_fetch_mem_read", 32'(ifc.mem_read), 1);

    // 16 R-type instructions wrap the 4-bit counter
    ifc.opcode = 6'h00;
    for (int n = 1; n <= 16; n++) begin
      step(4'd1);
      step(4'd6);
      step(4'd7);
      step(4'd0);
      if (n == 15) chk("wrap_count15", 32'(instr_count), 15);
    end
    chk("wrap_count0", 32'(instr_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
